// File: rtl/dtw_core_feeder.sv
// Sequences one DTW query: clear datapath, load squiggle, stream reference, drain, settle, report best hit.
// Latency: 1 clear cycle + SQG_LEN load beats + ref_len stream beats + drain-until-done + SETTLE cycles.
// Backpressure: sqg/ref tready only in their load/stream phases; REPORT holds until res_ready.
module dtw_core_feeder #(
    parameter int                  WORD_LEN = 16,
    parameter int                  SQG_LEN  = 250,
    parameter int                  SETTLE   = 3,
    parameter logic [WORD_LEN-1:0] PAD_WORD = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         ref_len_in,
    output logic                busy,
    input  logic [WORD_LEN-1:0] sqg_tdata,
    input  logic                sqg_tvalid,
    output logic                sqg_tready,
    input  logic [WORD_LEN-1:0] ref_tdata,
    input  logic                ref_tvalid,
    output logic                ref_tready,
    output logic                core_rst,
    output logic                load_squiggle,
    output logic [WORD_LEN-1:0] squiggle_word,
    output logic                running,
    output logic [WORD_LEN-1:0] reference_word,
    output logic [31:0]         reference_len,
    input  logic                core_done,
    input  logic [WORD_LEN-1:0] core_score,
    input  logic [31:0]         core_position,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WORD_LEN-1:0] res_score,
    output logic [31:0]         res_position
);

    localparam int LOAD_W = ($clog2(SQG_LEN + 1) > 8) ? $clog2(SQG_LEN + 1) : 8;
    localparam int SET_W  = ($clog2(SETTLE + 1) > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(SQG_LEN - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_SETTLE,
        S_REPORT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LOAD_W-1:0]  load_cnt;
    logic [31:0]        ref_cnt;
    logic [SET_W-1:0]   settle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            load_cnt      <= '0;
            ref_cnt       <= '0;
            settle_cnt    <= '0;
            reference_len <= '0;
            res_score     <= '1;
            res_position  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        reference_len <= ref_len_in;
                    end
                end
                S_CLEAR: begin
                    load_cnt   <= '0;
                    ref_cnt    <= '0;
                    settle_cnt <= '0;
                end
                S_LOAD: begin
                    if (sqg_tvalid) begin
                        load_cnt <= load_cnt + LOAD_W'(1);
                    end
                end
                S_STREAM: begin
                    if (ref_tvalid) begin
                        ref_cnt <= ref_cnt + 32'd1;
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    // Datapath best registers trail done by two cycles; sample on the final settle cycle.
                    if (settle_cnt == SET_LAST) begin
                        res_score    <= core_score;
                        res_position <= core_position;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b1;
        core_rst       = 1'b0;
        sqg_tready     = 1'b0;
        ref_tready     = 1'b0;
        load_squiggle  = 1'b0;
        squiggle_word  = '0;
        running        = 1'b0;
        reference_word = '0;
        res_valid      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                core_rst  = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                sqg_tready    = 1'b1;
                load_squiggle = sqg_tvalid;
                squiggle_word = sqg_tdata;
                if (sqg_tvalid && (load_cnt == LOAD_LAST)) begin
                    state_nxt = (reference_len == 32'd0) ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                // An empty reference input freezes the datapath rather than feeding a bubble.
                ref_tready     = 1'b1;
                running        = ref_tvalid;
                reference_word = ref_tdata;
                if (ref_tvalid && (ref_cnt == reference_len - 32'd1)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                running        = 1'b1;
                reference_word = PAD_WORD;
                if (core_done) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                running        = 1'b1;
                reference_word = PAD_WORD;
                if (settle_cnt == SET_LAST) begin
                    state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dtw_core_feeder.sv
// Bench for dtw_core_feeder: a behavioural datapath stand-in computes DTW from what the feeder delivers,
// while the bench predicts results from the stimulus it sent.
module tb_dtw_core_feeder;
    localparam int WL = 16;
    localparam int SQ = 4;
    localparam int ST = 3;

    logic        clk = 1'b0;
    logic        rst, start, busy;
    logic [31:0] ref_len_in, reference_len, core_position, res_position;
    logic [WL-1:0] sqg_tdata, ref_tdata, squiggle_word, reference_word, core_score, res_score;
    logic        sqg_tvalid, sqg_tready, ref_tvalid, ref_tready;
    logic        core_rst, load_squiggle, running, core_done, res_valid, res_ready;

    always #5 clk = ~clk;

    dtw_core_feeder #(.WORD_LEN(WL), .SQG_LEN(SQ), .SETTLE(ST), .PAD_WORD(16'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .ref_len_in(ref_len_in), .busy(busy),
        .sqg_tdata(sqg_tdata), .sqg_tvalid(sqg_tvalid), .sqg_tready(sqg_tready),
        .ref_tdata(ref_tdata), .ref_tvalid(ref_tvalid), .ref_tready(ref_tready),
        .core_rst(core_rst), .load_squiggle(load_squiggle), .squiggle_word(squiggle_word),
        .running(running), .reference_word(reference_word), .reference_len(reference_len),
        .core_done(core_done), .core_score(core_score), .core_position(core_position),
        .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score), .res_position(res_position)
    );

    // Subsequence DTW: free start column, best end over the last query row, first minimum wins.
    function automatic logic [47:0] dtw_ref(input logic [15:0] q [SQ], input logic [15:0] r [64], input int len);
        int d [SQ][64];
        int best, bpos, c, m;
        best = 65535;
        bpos = 0;
        for (int i = 0; i < SQ; i++) begin
            for (int j = 0; j < len; j++) begin
                c = (q[i] > r[j]) ? int'(q[i] - r[j]) : int'(r[j] - q[i]);
                if (i == 0) d[i][j] = c;
                else if (j == 0) d[i][j] = c + d[i-1][0];
                else begin
                    m = d[i-1][j];
                    if (d[i][j-1] < m) m = d[i][j-1];
                    if (d[i-1][j-1] < m) m = d[i-1][j-1];
                    d[i][j] = c + m;
                end
            end
        end
        for (int j = 0; j < len; j++) begin
            if (d[SQ-1][j] < best) begin
                best = d[SQ-1][j];
                bpos = j;
            end
        end
        return {best[15:0], bpos[31:0]};
    endfunction

    // Datapath stand-in: done SQ running cycles after the last reference word, best values two cycles later.
    logic [15:0] dp_q [SQ];
    logic [15:0] dp_r [64];
    int          dp_ld, dp_run;
    logic [15:0] dp_score;
    logic [31:0] dp_pos;

    always @(posedge clk) begin
        if (rst || core_rst) begin
            dp_ld    <= 0;
            dp_run   <= 0;
            dp_score <= 16'hFFFF;
            dp_pos   <= 32'd0;
        end else begin
            if (load_squiggle && dp_ld < SQ) begin
                dp_q[dp_ld] <= squiggle_word;
                dp_ld       <= dp_ld + 1;
            end
            if (running) begin
                if (dp_run < 64) dp_r[dp_run] <= reference_word;
                dp_run <= dp_run + 1;
                if (reference_len != 32'd0 && dp_run == int'(reference_len) + SQ + 2)
                    {dp_score, dp_pos} <= dtw_ref(dp_q, dp_r, int'(reference_len));
            end
        end
    end

    assign core_done     = (reference_len == 32'd0) || (dp_run >= int'(reference_len) + SQ);
    assign core_score    = dp_score;
    assign core_position = dp_pos;

    int          n_chk, n_err;
    int          n_load, n_ref, n_crst;
    logic [15:0] tq [SQ];
    logic [15:0] tr [64];
    logic [15:0] exp_score;
    logic [31:0] exp_pos;
    logic [47:0] pin;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (start && !busy) begin
                    n_load = 0;
                    n_ref  = 0;
                    n_crst = 0;
                end
                if (load_squiggle) n_load++;
                if (ref_tvalid && ref_tready) n_ref++;
                if (core_rst) n_crst++;
                chk(load_squiggle == (sqg_tvalid && sqg_tready), "load_vs_handshake", load_squiggle, sqg_tvalid && sqg_tready);
                chk(!(sqg_tready && ref_tready), "tready_exclusive", {sqg_tready, ref_tready}, 0);
                if (sqg_tready && sqg_tvalid) chk(squiggle_word == sqg_tdata, "squiggle_word", squiggle_word, sqg_tdata);
                if (ref_tready) chk(running == ref_tvalid, "running_mirrors_valid", running, ref_tvalid);
                if (ref_tready && ref_tvalid) chk(reference_word == ref_tdata, "reference_word", reference_word, ref_tdata);
                if (running && !ref_tready) chk(reference_word == 16'd0, "pad_word", reference_word, 0);
                if (res_valid) begin
                    chk(!sqg_tready && !ref_tready && !running, "report_quiet", {sqg_tready, ref_tready, running}, 0);
                    chk(res_score == exp_score, "res_score", res_score, exp_score);
                    chk(res_position == exp_pos, "res_position", res_position, exp_pos);
                end
                if (core_rst || sqg_tready || ref_tready || running || res_valid) chk(busy, "busy", busy, 1);
            end
        end
    endtask

    task automatic feed_sqg(input int n);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int t;
            acc = 0;
            t = 0;
            sqg_tvalid = 1'b1;
            sqg_tdata  = tq[i];
            while (!acc && t < 300) begin
                @(negedge clk);
                acc = sqg_tready;
                @(posedge clk);
                #1;
                t++;
            end
            chk(acc, "sqg_beat_timeout", acc, 1);
            if (!acc) break;
        end
        sqg_tvalid = 1'b0;
        sqg_tdata  = '0;
    endtask

    task automatic feed_ref(input int len, input bit stall);
        for (int i = 0; i < len; i++) begin
            bit acc;
            int t;
            acc = 0;
            t = 0;
            ref_tvalid = 1'b1;
            ref_tdata  = tr[i];
            while (!acc && t < 300) begin
                @(negedge clk);
                acc = ref_tready;
                @(posedge clk);
                #1;
                t++;
            end
            chk(acc, "ref_beat_timeout", acc, 1);
            if (!acc) break;
            if (stall && i < len - 1) begin
                ref_tvalid = 1'b0;
                ref_tdata  = 16'h5A5A;
                @(posedge clk);
                #1;
            end
        end
        if (len != 0) begin
            ref_tvalid = 1'b0;
            ref_tdata  = '0;
        end
    endtask

    task automatic poke_start(input int len);
        int t;
        t = 0;
        while (!ref_tready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(ref_tready, "stream_timeout", ref_tready, 1);
        @(posedge clk);
        #1;
        start      = 1'b1;
        ref_len_in = 32'd99;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk(reference_len == 32'(len), "ref_len_kept", reference_len, len);
    endtask

    task automatic wait_result(input int len, input int hold);
        int t;
        logic [15:0] s0;
        t = 0;
        while (!res_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(res_valid, "res_valid_timeout", res_valid, 1);
        chk(res_score == exp_score, "result_score", res_score, exp_score);
        chk(res_position == exp_pos, "result_position", res_position, exp_pos);
        chk(n_load == SQ, "load_pulses", n_load, SQ);
        chk(n_ref == len, "ref_beats", n_ref, len);
        chk(n_crst == 1, "core_rst_cycles", n_crst, 1);
        if (hold > 0) begin
            s0 = res_score;
            sqg_tvalid = 1'b1;
            ref_tvalid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                chk(res_valid && res_score == s0, "report_hold", {res_valid, res_score}, {1'b1, s0});
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready  = 1'b0;
        sqg_tvalid = 1'b0;
        ref_tvalid = 1'b0;
        @(negedge clk);
        chk(!res_valid && !busy, "back_to_idle", {res_valid, busy}, 0);
        chk(n_load == SQ && n_ref == len, "no_extra_beats", n_load + n_ref, SQ + len);
    endtask

    task automatic run_query(input int len, input bit stall, input bit restart, input int hold);
        {exp_score, exp_pos} = (len == 0) ? {16'hFFFF, 32'd0} : dtw_ref(tq, tr, len);
        @(posedge clk);
        #1;
        start      = 1'b1;
        ref_len_in = 32'(len);
        if (len == 0) begin
            ref_tvalid = 1'b1;
            ref_tdata  = 16'd7;
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        ref_len_in = 32'hDEAD;
        fork
            feed_sqg(SQ);
            feed_ref(len, stall);
            if (restart) poke_start(len);
        join
        wait_result(len, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_err = 0; n_load = 0; n_ref = 0; n_crst = 0;
        rst = 1'b1; start = 1'b0; ref_len_in = '0; res_ready = 1'b0;
        sqg_tvalid = 1'b0; sqg_tdata = '0; ref_tvalid = 1'b0; ref_tdata = '0;
        exp_score = 16'hFFFF; exp_pos = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!busy && !sqg_tready && !ref_tready && !core_rst, "reset_ctrl", {busy, sqg_tready, ref_tready, core_rst}, 0);
        chk(!load_squiggle && !running && !res_valid, "reset_dp", {load_squiggle, running, res_valid}, 0);
        chk(res_score == 16'hFFFF, "reset_score", res_score, 16'hFFFF);
        chk(res_position == 32'd0 && reference_len == 32'd0, "reset_pos_len", {res_position, reference_len}, 0);
        chk(squiggle_word == 16'd0 && reference_word == 16'd0, "reset_words", {squiggle_word, reference_word}, 0);
        start = 1'b1;
        ref_len_in = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk(!busy && reference_len == 32'd0, "start_with_rst", {busy, reference_len}, 0);

        tq = '{16'd1, 16'd2, 16'd3, 16'd4};
        for (int j = 0; j < 64; j++) tr[j] = 16'd0;
        tr[0] = 16'd9; tr[1] = 16'd1; tr[2] = 16'd2; tr[3] = 16'd3; tr[4] = 16'd4; tr[5] = 16'd9;
        pin = dtw_ref(tq, tr, 6);
        chk(pin == {16'd0, 32'd4}, "model_pin_exact", pin, {16'd0, 32'd4});

        run_query(6, 1'b0, 1'b0, 0);
        run_query(6, 1'b1, 1'b0, 0);
        run_query(6, 1'b0, 1'b0, 20);
        run_query(6, 1'b0, 1'b1, 0);

        tq = '{16'd5, 16'd0, 16'd5, 16'd0};
        for (int j = 0; j < 64; j++) tr[j] = 16'd0;
        pin = dtw_ref(tq, tr, 6);
        chk(pin == {16'd10, 32'd0}, "model_pin_flat", pin, {16'd10, 32'd0});
        @(posedge clk);
        #1;
        start = 1'b1;
        ref_len_in = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        feed_sqg(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(!busy && !sqg_tready && reference_len == 32'd0, "abort_to_idle", {busy, sqg_tready, reference_len}, 0);
        run_query(6, 1'b0, 1'b0, 0);

        run_query(0, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
